// File: rtl/backoff_array.sv
// Multi-channel exponential backoff timer with optional LFSR jitter.
// Each channel waits base<<exp (+jitter, saturated) cycles, then pulses ack once.
module backoff_array #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter int          MAX_EXP   = 6,
    parameter bit          JITTER_EN = 1'b1,
    parameter int          JIT_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      base_value,
    input  logic [NUM_CH-1:0]     valid,
    input  logic [NUM_CH-1:0]     interrupt,
    input  logic [NUM_CH-1:0]     success,
    output logic [NUM_CH-1:0]     ack,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH*4-1:0]   exp_o
);
    localparam int EXT_W = CNT_W + 16;
    localparam logic [EXT_W-1:0] JIT_MASK = (EXT_W'(1'b1) << JIT_W) - EXT_W'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BACKOFF = 2'd1,
        S_ACK     = 2'd2
    } state_t;

    state_t           state_r   [NUM_CH];
    logic [CNT_W-1:0] counter_r [NUM_CH];
    logic [CNT_W-1:0] target_r  [NUM_CH];
    logic [CNT_W-1:0] target_s  [NUM_CH];
    logic [3:0]       exp_r     [NUM_CH];
    logic [15:0]      lfsr_r;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int sh);
        logic [31:0] d;
        d = {v, v} << sh;
        return d[31:16];
    endfunction

    // Per-channel target candidate: widened shift plus jitter, clamped to all-ones.
    always_comb begin
        logic [EXT_W-1:0] shifted_s;
        logic [EXT_W-1:0] jit_s;
        logic [EXT_W-1:0] sum_s;
        shifted_s = {EXT_W{1'b0}};
        jit_s     = {EXT_W{1'b0}};
        sum_s     = {EXT_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            shifted_s = EXT_W'(base_value) << exp_r[i];
            if (JITTER_EN) begin
                jit_s = EXT_W'(rotl16(lfsr_r, (4 * i) % 16)) & JIT_MASK;
            end else begin
                jit_s = {EXT_W{1'b0}};
            end
            sum_s = shifted_s + jit_s;
            if (|sum_s[EXT_W-1:CNT_W]) begin
                target_s[i] = {CNT_W{1'b1}};
            end else begin
                target_s[i] = sum_s[CNT_W-1:0];
            end
        end
    end

    // Channel FSMs, exponent tracking and the free-running LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i]   <= S_IDLE;
                counter_r[i] <= {CNT_W{1'b0}};
                target_r[i]  <= {CNT_W{1'b0}};
                exp_r[i]     <= 4'd0;
            end
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_r[i])
                    S_IDLE: begin
                        if (valid[i]) begin
                            target_r[i]  <= target_s[i];
                            counter_r[i] <= {CNT_W{1'b0}};
                            state_r[i]   <= S_BACKOFF;
                        end
                    end
                    S_BACKOFF: begin
                        if (interrupt[i]) begin
                            counter_r[i] <= {CNT_W{1'b0}};
                            state_r[i]   <= S_IDLE;
                        end else if (counter_r[i] == target_r[i]) begin
                            state_r[i] <= S_ACK;
                            if (exp_r[i] < 4'(MAX_EXP)) begin
                                exp_r[i] <= exp_r[i] + 4'd1;
                            end
                        end else begin
                            counter_r[i] <= counter_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    S_ACK: begin
                        counter_r[i] <= {CNT_W{1'b0}};
                        state_r[i]   <= S_IDLE;
                    end
                    default: begin
                        counter_r[i] <= {CNT_W{1'b0}};
                        state_r[i]   <= S_IDLE;
                    end
                endcase
                // A success pulse overrides any increment issued in the same cycle.
                if (success[i]) begin
                    exp_r[i] <= 4'd0;
                end
            end
        end
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        ack   = {NUM_CH{1'b0}};
        busy  = {NUM_CH{1'b0}};
        exp_o = {(NUM_CH*4){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            ack[i]          = (state_r[i] == S_ACK);
            busy[i]         = (state_r[i] != S_IDLE);
            exp_o[4*i +: 4] = exp_r[i];
        end
    end
endmodule
